// File: rtl/controller_pkg.sv
// Shared encodings for the controller: opcodes, control-field enums and the registered control bundle.
// AUIPC decode is enabled by defining CTRL_AUIPC_EN.
package controller_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic {
        SRCA_RS1 = 1'b0,
        SRCA_PC  = 1'b1
    } srca_e;

    typedef enum logic [2:0] {
        SRCB_RS2  = 3'b000,
        SRCB_IMMI = 3'b001,
        SRCB_IMMS = 3'b010,
        SRCB_IMMB = 3'b011,
        SRCB_IMMU = 3'b100,
        SRCB_IMMJ = 3'b101
    } srcb_e;

    typedef enum logic [2:0] {
        WB_ALU  = 3'b000,
        WB_MEM  = 3'b001,
        WB_PC4  = 3'b010,
        WB_IMMU = 3'b011
    } wb_e;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'b00000,
        ALU_SUB  = 5'b00001,
        ALU_SLL  = 5'b00010,
        ALU_SLT  = 5'b00011,
        ALU_SLTU = 5'b00100,
        ALU_XOR  = 5'b00101,
        ALU_SRL  = 5'b00110,
        ALU_SRA  = 5'b00111,
        ALU_OR   = 5'b01000,
        ALU_AND  = 5'b01001
    } alu_e;

    typedef enum logic [2:0] {
        BR_NONE = 3'b000,
        BR_BEQ  = 3'b001,
        BR_BNE  = 3'b010,
        BR_BLT  = 3'b011,
        BR_BGE  = 3'b100,
        BR_BLTU = 3'b101,
        BR_BGEU = 3'b110,
        BR_JUMP = 3'b111
    } br_e;

    typedef struct packed {
        logic  reg_write;
        logic  mem_write;
        srcb_e src_b;
        srca_e src_a;
        wb_e   mem_to_reg;
        alu_e  alu_control;
        br_e   branch_control;
        logic  illegal;
    } ctrl_t;

    // alt selects the funct7=0100000 variant (SUB / SRA); caller checks legality.
    function automatic alu_e alu_from_funct3(input logic [2:0] f3, input logic alt);
        alu_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/controller_decode.sv
// Combinational instruction decode producing the unregistered control bundle.
// Honours CTRL_AUIPC_EN for the AUIPC opcode.
module controller_decode
    import controller_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output ctrl_t      ctrl
);

    logic bad;
    logic alt_ok;

    // funct7=0100000 is only meaningful for funct3 000 (R-type SUB) and 101 (SRA).
    assign alt_ok = (funct7 == F7_ALT) && (funct3 == 3'b000 || funct3 == 3'b101);

    always_comb begin
        ctrl = '0;
        bad  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                if (funct7 == F7_BASE)
                    ctrl.alu_control = alu_from_funct3(funct3, 1'b0);
                else if (alt_ok)
                    ctrl.alu_control = alu_from_funct3(funct3, 1'b1);
                else
                    bad = 1'b1;
            end
            OP_IALU: begin
                ctrl.reg_write   = 1'b1;
                ctrl.src_b       = SRCB_IMMI;
                ctrl.alu_control = alu_from_funct3(funct3, 1'b0);
                if (funct3 == 3'b001 && funct7 != F7_BASE)
                    bad = 1'b1;
                if (funct3 == 3'b101) begin
                    if (funct7 == F7_ALT)
                        ctrl.alu_control = ALU_SRA;
                    else if (funct7 != F7_BASE)
                        bad = 1'b1;
                end
            end
            OP_LOAD: begin
                ctrl.reg_write  = 1'b1;
                ctrl.src_b      = SRCB_IMMI;
                ctrl.mem_to_reg = WB_MEM;
                bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OP_STORE: begin
                ctrl.mem_write = 1'b1;
                ctrl.src_b     = SRCB_IMMS;
                bad = (funct3 > 3'b010);
            end
            OP_BRANCH: begin
                ctrl.src_a = SRCA_PC;
                ctrl.src_b = SRCB_IMMB;
                case (funct3)
                    3'b000:  ctrl.branch_control = BR_BEQ;
                    3'b001:  ctrl.branch_control = BR_BNE;
                    3'b100:  ctrl.branch_control = BR_BLT;
                    3'b101:  ctrl.branch_control = BR_BGE;
                    3'b110:  ctrl.branch_control = BR_BLTU;
                    3'b111:  ctrl.branch_control = BR_BGEU;
                    default: bad = 1'b1;
                endcase
            end
            OP_JALR: begin
                ctrl.reg_write      = 1'b1;
                ctrl.src_b          = SRCB_IMMI;
                ctrl.mem_to_reg     = WB_PC4;
                ctrl.branch_control = BR_JUMP;
                bad = (funct3 != 3'b000);
            end
            OP_JAL: begin
                ctrl.reg_write      = 1'b1;
                ctrl.src_a          = SRCA_PC;
                ctrl.src_b          = SRCB_IMMJ;
                ctrl.mem_to_reg     = WB_PC4;
                ctrl.branch_control = BR_JUMP;
            end
            OP_LUI: begin
                ctrl.reg_write  = 1'b1;
                ctrl.src_b      = SRCB_IMMU;
                ctrl.mem_to_reg = WB_IMMU;
            end
`ifdef CTRL_AUIPC_EN
            OP_AUIPC: begin
                ctrl.reg_write = 1'b1;
                ctrl.src_a     = SRCA_PC;
                ctrl.src_b     = SRCB_IMMU;
            end
`endif
            default: bad = 1'b1;
        endcase

        if (bad) begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/controller.sv
// Instruction-decode controller: registers the decoded control bundle with stall/flush/async reset.
// Define CTRL_AUIPC_EN to decode AUIPC; otherwise it is reported as illegal.
module controller
    import controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       stall,
    input  logic       flush,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [3:0] ALUSrc,
    output logic [2:0] MemtoReg,
    output logic [4:0] ALUControl,
    output logic [2:0] BranchControl,
    output logic       IllegalInstr
);

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    controller_decode u_decode (
        .opcode (opcode),
        .funct3 (funct3),
        .funct7 (funct7),
        .ctrl   (ctrl_d)
    );

    // Flush outranks stall so a bubble can be injected into a held stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ctrl_q <= '0;
        else if (flush)
            ctrl_q <= '0;
        else if (!stall)
            ctrl_q <= ctrl_d;
    end

    assign RegWrite      = ctrl_q.reg_write;
    assign MemWrite      = ctrl_q.mem_write;
    assign ALUSrc        = {ctrl_q.src_b, ctrl_q.src_a};
    assign MemtoReg      = ctrl_q.mem_to_reg;
    assign ALUControl    = ctrl_q.alu_control;
    assign BranchControl = ctrl_q.branch_control;
    assign IllegalInstr  = ctrl_q.illegal;

endmodule

// File: tb/tb_controller.sv
// Self-checking bench for controller: per-cycle behavioural model comparison plus literal spot checks.
// Expectations for opcode 0010111 follow CTRL_AUIPC_EN.
module tb_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic [6:0] funct7 = '0;
    logic       stall = 1'b0;
    logic       flush = 1'b0;
    logic       RegWrite, MemWrite, IllegalInstr;
    logic [3:0] ALUSrc;
    logic [2:0] MemtoReg, BranchControl;
    logic [4:0] ALUControl;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic checking = 1'b0;
    logic [17:0] exp_q;

    always #5 clk = ~clk;

    controller dut (
        .clk           (clk),
        .rst           (rst),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7        (funct7),
        .stall         (stall),
        .flush         (flush),
        .RegWrite      (RegWrite),
        .MemWrite      (MemWrite),
        .ALUSrc        (ALUSrc),
        .MemtoReg      (MemtoReg),
        .ALUControl    (ALUControl),
        .BranchControl (BranchControl),
        .IllegalInstr  (IllegalInstr)
    );

    wire [17:0] dut_vec = {RegWrite, MemWrite, ALUSrc, MemtoReg, ALUControl, BranchControl, IllegalInstr};

    // ALU codes are ordered so the funct7 "alternate" op is always base+1.
    function automatic logic [4:0] alu_base(input logic [2:0] f3);
        case (f3)
            3'd0: return 5'd0;
            3'd1: return 5'd2;
            3'd2: return 5'd3;
            3'd3: return 5'd4;
            3'd4: return 5'd5;
            3'd5: return 5'd6;
            3'd6: return 5'd8;
            default: return 5'd9;
        endcase
    endfunction

    function automatic logic [17:0] model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        logic rw, mw, sa, ill;
        logic [2:0] sb, mtr, br;
        logic [4:0] alu;
        rw = 0; mw = 0; sa = 0; ill = 0; sb = 0; mtr = 0; br = 0; alu = 0;
        case (op)
            7'h33: begin
                rw = 1; alu = alu_base(f3);
                if (f7 == 7'h20 && (f3 == 0 || f3 == 5)) alu = alu + 5'd1;
                else if (f7 != 0) ill = 1;
            end
            7'h13: begin
                rw = 1; sb = 1; alu = alu_base(f3);
                if (f3 == 1 && f7 != 0) ill = 1;
                if (f3 == 5) begin
                    if (f7 == 7'h20) alu = alu + 5'd1;
                    else if (f7 != 0) ill = 1;
                end
            end
            7'h03: begin rw = 1; sb = 1; mtr = 1; ill = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}); end
            7'h23: begin mw = 1; sb = 2; ill = (f3 > 2); end
            7'h63: begin
                sa = 1; sb = 3;
                case (f3)
                    3'd0: br = 1; 3'd1: br = 2; 3'd4: br = 3;
                    3'd5: br = 4; 3'd6: br = 5; 3'd7: br = 6;
                    default: ill = 1;
                endcase
            end
            7'h67: begin rw = 1; sb = 1; mtr = 2; br = 7; ill = (f3 != 0); end
            7'h6F: begin rw = 1; sa = 1; sb = 5; mtr = 2; br = 7; end
            7'h37: begin rw = 1; sb = 4; mtr = 3; end
`ifdef CTRL_AUIPC_EN
            7'h17: begin rw = 1; sa = 1; sb = 4; end
`endif
            default: ill = 1;
        endcase
        if (ill) return 18'd1;
        return {rw, mw, sb, sa, mtr, alu, br, 1'b0};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst)        exp_q <= '0;
        else if (flush) exp_q <= '0;
        else if (!stall) exp_q <= model(opcode, funct3, funct7);
    end

    always @(negedge clk) begin
        if (checking) begin
            total_cnt++;
            if (dut_vec === exp_q) pass_cnt++;
            else $display("FAIL model t=%0t op=%b f3=%b f7=%b got=%b want=%b",
                          $time, opcode, funct3, funct7, dut_vec, exp_q);
        end
    end

    task automatic check_lit(input string name, input logic [17:0] want);
        total_cnt++;
        if (dut_vec === want) pass_cnt++;
        else $display("FAIL %s got=%b want=%b", name, dut_vec, want);
    endtask

    task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic st, input logic fl);
        opcode = op; funct3 = f3; funct7 = f7; stall = st; flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h37, 7'h17, 7'h7F};
    logic [6:0] f7s [3]  = '{7'h00, 7'h20, 7'h01};

    initial begin
        #3;
        check_lit("reset_zero", 18'd0);
        @(negedge clk);
        rst = 1'b0;
        checking = 1'b1;
        tick();

        // R-type SUB
        drive(7'b0110011, 3'b000, 7'b0100000, 0, 0); tick();
        check_lit("rtype_sub", {1'b1, 1'b0, 4'b0000, 3'b000, 5'b00001, 3'b000, 1'b0});
        // Load word then store word
        drive(7'b0000011, 3'b010, 7'b0, 0, 0); tick();
        check_lit("load_lw", {1'b1, 1'b0, 4'b0010, 3'b001, 5'b00000, 3'b000, 1'b0});
        drive(7'b0100011, 3'b010, 7'b0, 0, 0); tick();
        check_lit("store_sw", {1'b0, 1'b1, 4'b0100, 3'b000, 5'b00000, 3'b000, 1'b0});
        // Branch BGE, then illegal branch funct3
        drive(7'b1100011, 3'b101, 7'b0, 0, 0); tick();
        check_lit("branch_bge", {1'b0, 1'b0, 4'b0111, 3'b000, 5'b00000, 3'b100, 1'b0});
        drive(7'b1100011, 3'b010, 7'b0, 0, 0); tick();
        check_lit("branch_illegal", {17'd0, 1'b1});
        // Jumps and LUI
        drive(7'b1101111, 3'b000, 7'b0, 0, 0); tick();
        check_lit("jal", {1'b1, 1'b0, 4'b1011, 3'b010, 5'b00000, 3'b111, 1'b0});
        drive(7'b1100111, 3'b000, 7'b0, 0, 0); tick();
        check_lit("jalr", {1'b1, 1'b0, 4'b0010, 3'b010, 5'b00000, 3'b111, 1'b0});
        drive(7'b0110111, 3'b000, 7'b0, 0, 0); tick();
        check_lit("lui", {1'b1, 1'b0, 4'b1000, 3'b011, 5'b00000, 3'b000, 1'b0});
        // I-type SRAI and an illegal SLLI funct7
        drive(7'b0010011, 3'b101, 7'b0100000, 0, 0); tick();
        check_lit("srai", {1'b1, 1'b0, 4'b0010, 3'b000, 5'b00111, 3'b000, 1'b0});
        drive(7'b0010011, 3'b001, 7'b0100000, 0, 0); tick();
        check_lit("slli_illegal", {17'd0, 1'b1});

        // Stall holds, flush wins over stall
        drive(7'b0110011, 3'b000, 7'b0100000, 0, 0); tick();
        drive(7'b0110111, 3'b000, 7'b0, 1, 0); tick();
        check_lit("stall_hold1", {1'b1, 1'b0, 4'b0000, 3'b000, 5'b00001, 3'b000, 1'b0});
        drive(7'b1101111, 3'b000, 7'b0, 1, 0); tick();
        check_lit("stall_hold2", {1'b1, 1'b0, 4'b0000, 3'b000, 5'b00001, 3'b000, 1'b0});
        drive(7'b1101111, 3'b000, 7'b0, 1, 1); tick();
        check_lit("flush_over_stall", 18'd0);

        // Async reset between edges
        drive(7'b0110111, 3'b000, 7'b0, 0, 0); tick();
        rst = 1'b1; #1;
        check_lit("async_reset", 18'd0);
        #1 rst = 1'b0; #1;
        check_lit("hold_until_edge", 18'd0);
        tick();
        check_lit("after_reset_lui", {1'b1, 1'b0, 4'b1000, 3'b011, 5'b00000, 3'b000, 1'b0});

        // AUIPC
        drive(7'b0010111, 3'b000, 7'b0, 0, 0); tick();
`ifdef CTRL_AUIPC_EN
        check_lit("auipc", {1'b1, 1'b0, 4'b1001, 3'b000, 5'b00000, 3'b000, 1'b0});
`else
        check_lit("auipc_illegal", {17'd0, 1'b1});
`endif

        // Sweep opcodes x funct3 x funct7 with occasional stall/flush
        for (int i = 0; i < 10; i++)
            for (int j = 0; j < 8; j++)
                for (int k = 0; k < 3; k++) begin
                    drive(ops[i], 3'(j), f7s[k], (j == 3 && k == 1), (j == 6 && k == 2));
                    tick();
                end

        drive(7'b0, 3'b0, 7'b0, 0, 0);
        tick();
        @(negedge clk);
        checking = 1'b0;
        #1;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/controller.md
CONTROLLER -- requirements
Module: controller

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-high.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-004 SHALL have port opcode, input, 7 bits: instruction bits [6:0].
REQ-005 SHALL have port funct3, input, 3 bits: instruction bits [14:12].
REQ-006 SHALL have port funct7, input, 7 bits: instruction bits [31:25].
REQ-007 SHALL have port stall, input, 1 bit: hold all outputs.
REQ-008 SHALL have port flush, input, 1 bit: load bubble (all-zero outputs) next edge.
REQ-009 SHALL have port RegWrite, output, 1 bit: write rd.
REQ-010 SHALL have port MemWrite, output, 1 bit: store to data memory.
REQ-011 SHALL have port ALUSrc, output, 4 bits, with fields below.
  - [0] SrcA: 0 = rs1, 1 = PC.
  - [3:1] SrcB: 000 = rs2, 001 = immI, 010 = immS, 011 = immB, 100 = immU, 101 = immJ.
REQ-012 SHALL have port MemtoReg, output, 3 bits, selecting the writeback source: 000 = ALU, 001 = memory, 010 = PC+4, 011 = immU.
REQ-013 SHALL have port ALUControl, output, 5 bits, encoded as ADD 00000, SUB 00001, SLL 00010, SLT 00011, SLTU 00100, XOR 00101, SRL 00110, SRA 00111, OR 01000, AND 01001.
REQ-014 SHALL have port BranchControl, output, 3 bits, encoded as none 000, BEQ 001, BNE 010, BLT 011, BGE 100, BLTU 101, BGEU 110, JUMP 111.
REQ-015 SHALL have port IllegalInstr, output, 1 bit: unsupported encoding decoded.

Function
REQ-016 SHALL decode combinationally, then register all outputs on the rising clk; latency is exactly 1 cycle.
REQ-017 SHALL decode R-type (0110011) as: RegWrite=1, ALUSrc=0000, MemtoReg=000, ALUControl from funct3.
  - funct7=0100000 selects SUB when funct3=000, SRA when funct3=101.
  - Other funct7 values besides 0000000 are illegal.
REQ-018 SHALL decode I-ALU (0010011) like R-type, with these differences:
  - SrcB = immI; funct3=000 is always ADD.
  - Shifts: funct3=001 requires funct7=0000000; funct3=101 requires funct7 of 0000000 (SRL) or 0100000 (SRA); otherwise illegal.
REQ-019 SHALL decode Load (0000011) as: RegWrite=1, SrcB=immI, ADD, MemtoReg=001; funct3 of 011, 110, 111 are illegal.
REQ-020 SHALL decode Store (0100011) as: MemWrite=1, RegWrite=0, SrcB=immS, ADD; funct3 greater than 010 is illegal.
REQ-021 SHALL decode Branch (1100011) as: SrcA=PC, SrcB=immB, ADD (target address), BranchControl from funct3 (000→BEQ, 001→BNE, 100→BLT, 101→BGE, 110→BLTU, 111→BGEU); funct3 of 010 or 011 is illegal.
REQ-022 SHALL decode JALR (1100111) as: RegWrite=1, SrcA=rs1, SrcB=immI, ADD, MemtoReg=010, BranchControl=JUMP; funct3 other than 000 is illegal.
REQ-023 SHALL decode JAL (1101111) as: RegWrite=1, SrcA=PC, SrcB=immJ, ADD, MemtoReg=010, BranchControl=JUMP.
REQ-024 SHALL decode LUI (0110111) as: RegWrite=1, SrcB=immU, MemtoReg=011, ADD.
REQ-025 SHALL register, for any illegal or unknown encoding, all control outputs at zero and IllegalInstr=1.
REQ-026 SHALL register all-zero outputs (including IllegalInstr) on flush; flush has priority over stall.
REQ-027 SHALL keep the registers unchanged while stall=1 and flush=0.

Reset
REQ-028 SHALL force all outputs to 0 immediately on rst=1, independent of clk.
REQ-029 SHALL, after rst deasserts, update outputs at the first rising edge only.

Configuration
REQ-030 SHALL decode AUIPC (0010111) only when CTRL_AUIPC_EN is defined: RegWrite=1, SrcA=PC, SrcB=immU, ADD, MemtoReg=000.
REQ-031 SHALL treat 0010111 as illegal (REQ-025) when CTRL_AUIPC_EN is undefined.

Structure
REQ-032 SHALL keep opcode constants and the ALUSrc, MemtoReg, ALUControl and BranchControl encodings in the shared package controller_pkg.
REQ-033 SHALL place the combinational decode in one sub-module, controller_decode; the top module holds only the output register, stall, flush and reset logic.

Verification
REQ-034 SHALL cover: opcode 0110011, funct3 000, funct7 0100000 → next edge: RegWrite=1, ALUSrc=0000, MemtoReg=000, ALUControl=00001, BranchControl=000.
REQ-035 SHALL cover: opcode 0000011, funct3 010 → RegWrite=1, ALUSrc=0010, MemtoReg=001, MemWrite=0; then 0100011, funct3 010 → MemWrite=1, RegWrite=0, ALUSrc=0100.
REQ-036 SHALL cover: opcode 1100011, funct3 101 → BranchControl=100, ALUSrc=0111; funct3 010 → IllegalInstr=1, all other outputs 0.
REQ-037 SHALL cover: opcode 1101111 → BranchControl=111, MemtoReg=010, ALUSrc=1011; 1100111 → BranchControl=111, ALUSrc=0010; 0110111 → MemtoReg=011, ALUSrc=1000.
REQ-038 SHALL cover: R-type held with stall=1 while opcode changes → outputs unchanged; assert flush with stall → zero next edge.
REQ-039 SHALL cover: rst pulse between clock edges → outputs 0 immediately; opcode 0010111 → AUIPC decode with CTRL_AUIPC_EN defined, IllegalInstr=1 without it.
